// File: rtl/tile_window_buf.sv
// tile_window_buf: loads a TILE_DIM x TILE_DIM pixel tile in LANES-wide column beats,
// then streams 3x3 neighbourhood windows in row-major order of their centres.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   pix_in    - LANES pixels of one beat, lane 0 is the topmost row
//   in_valid  - pix_in holds a beat
//   in_ready  - a beat is accepted this cycle (tile loading)
//   pad_mode  - 0 interior windows only, 1 edge-replicated windows (sampled on beat 0)
//   win_out   - 3x3 window, element (r,c) at [(r*3+c)*PIX_W +: PIX_W]
//   win_valid - win_out holds a window
//   win_ready - consumer takes the window
//   win_last  - win_out is the final window of the tile
module tile_window_buf #(
    parameter int PIX_W    = 4,
    parameter int LANES    = 5,
    parameter int TILE_DIM = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*PIX_W-1:0] pix_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   pad_mode,
    output logic [9*PIX_W-1:0]     win_out,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   win_last
);
    localparam int NG = TILE_DIM / LANES;
    localparam int CW = $clog2(TILE_DIM);
    localparam int GW = NG > 1 ? $clog2(NG) : 1;
    localparam int IW = $clog2(TILE_DIM * TILE_DIM);
    localparam logic [CW-1:0] EDGE  = CW'(TILE_DIM - 1);
    localparam logic [GW-1:0] GLAST = GW'(NG - 1);

    typedef enum logic {LOAD, STREAM} state_t;

    state_t          state, state_nxt;
    logic [PIX_W-1:0] mem [TILE_DIM*TILE_DIM];
    logic [CW-1:0]   col, nr, nc, lo, hi;
    logic [GW-1:0]   grp;
    logic [CW-1:0]   ra [3];
    logic [CW-1:0]   ca [3];
    logic [9*PIX_W-1:0] win_nxt;
    logic            mode, primed, acc, last_beat, adv, done;

    assign acc       = in_valid && in_ready;
    assign last_beat = acc && col == EDGE && grp == GLAST;
    // primed marks the single prefetch cycle spent in STREAM before window 0
    assign adv       = state == STREAM && primed && (!win_valid || (win_ready && !win_last));
    assign done      = win_valid && win_ready && win_last;
    assign lo        = mode ? '0 : CW'(1);
    assign hi        = mode ? EDGE : CW'(TILE_DIM - 2);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= LOAD;
        else        state <= state_nxt;

    always_comb
        state_nxt = (state == LOAD) ? (last_beat ? STREAM : LOAD) : (done ? LOAD : STREAM);

    always_comb
        in_ready = state == LOAD;

    // beat k lands in column k % TILE_DIM, row group k / TILE_DIM
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            col  <= '0;
            grp  <= '0;
            mode <= 1'b0;
        end else if (acc) begin
            col <= col == EDGE ? '0 : col + 1'b1;
            if (col == EDGE) grp <= grp == GLAST ? '0 : grp + 1'b1;
            if (col == '0 && grp == '0) mode <= pad_mode;
        end

    always_ff @(posedge clk)
        if (acc)
            for (int l = 0; l < LANES; l++)
                mem[IW'((int'(grp) * LANES + l) * TILE_DIM + int'(col))] <= pix_in[l*PIX_W +: PIX_W];

    // neighbour coordinates clamp to the tile; interior centres never reach the clamp
    always_comb begin
        ra[0] = nr == '0 ? '0 : nr - 1'b1;
        ra[1] = nr;
        ra[2] = nr == EDGE ? EDGE : nr + 1'b1;
        ca[0] = nc == '0 ? '0 : nc - 1'b1;
        ca[1] = nc;
        ca[2] = nc == EDGE ? EDGE : nc + 1'b1;
        win_nxt = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win_nxt[(r*3+c)*PIX_W +: PIX_W] = mem[IW'(int'(ra[r]) * TILE_DIM + int'(ca[c]))];
    end

    // nr/nc always point at the next centre to be presented
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            nr        <= '0;
            nc        <= '0;
            primed    <= 1'b0;
            win_out   <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (state == LOAD) begin
            nr     <= lo;
            nc     <= lo;
            primed <= 1'b0;
        end else if (!primed) begin
            primed <= 1'b1;
        end else if (done) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (adv) begin
            win_out   <= win_nxt;
            win_valid <= 1'b1;
            win_last  <= nr == hi && nc == hi;
            nc        <= nc == hi ? lo : nc + 1'b1;
            if (nc == hi) nr <= nr + 1'b1;
        end
endmodule
